// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store engine for a single-port
// 32-bit data memory with asynchronous read. Sub-word stores are done as a
// read-modify-write (READ -> WRITE). Misaligned, illegal-size and
// out-of-range accesses complete with err=1 and never touch memory.
// Optional feature macro: FAST_WORD_STORE_EN -- legal word stores skip the
// READ phase and write wdata directly.
module load_store_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One past the last legal byte address; 33 bits so the bound cannot wrap.
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    state_t      state_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        sign_ext_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] word_reg;
    logic        ready_reg;
    logic        done_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    logic        req_err;
    logic        fast_store;
    logic [31:0] wdata_lanes;
    logic [3:0]  byte_en;
    logic [31:0] merged_word;
    logic [31:0] lane_word;
    logic [31:0] load_value;

    // Classify the incoming request (uses live inputs, only meaningful in IDLE).
    always_comb begin
        req_err = 1'b0;
        case (size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = addr[0];
            2'b10:   req_err = (addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if ({1'b0, addr} >= ADDR_LIMIT) begin
            req_err = 1'b1;
        end
    end

    // Legal word stores may bypass the read phase when the fast path is built in.
`ifdef FAST_WORD_STORE_EN
    assign fast_store = we && (size == 2'b10);
`else
    assign fast_store = 1'b0;
`endif

    // Replicate store data across lanes and pick which byte lanes it replaces.
    always_comb begin
        wdata_lanes = wdata_reg;
        byte_en     = 4'b1111;
        case (size_reg)
            2'b00: begin
                wdata_lanes = {4{wdata_reg[7:0]}};
                byte_en     = 4'b0001 << addr_reg[1:0];
            end
            2'b01: begin
                wdata_lanes = {2{wdata_reg[15:0]}};
                byte_en     = addr_reg[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_lanes = wdata_reg;
                byte_en     = 4'b1111;
            end
        endcase
    end

    // Per-lane merge of new store data into the captured memory word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = byte_en[gi] ? wdata_lanes[8*gi +: 8]
                                                        : word_reg[8*gi +: 8];
        end
    endgenerate

    // Right-align the addressed lane of the memory word and extend it.
    always_comb begin
        lane_word  = mem_rd >> {addr_reg[1:0], 3'b000};
        load_value = mem_rd;
        case (size_reg)
            2'b00:   load_value = {{24{sign_ext_reg & lane_word[7]}}, lane_word[7:0]};
            2'b01:   load_value = {{16{sign_ext_reg & lane_word[15]}}, lane_word[15:0]};
            default: load_value = mem_rd;
        endcase
    end

    // Main FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            sign_ext_reg <= 1'b0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            word_reg     <= 32'd0;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            rdata_reg    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        we_reg       <= we;
                        size_reg     <= size;
                        sign_ext_reg <= sign_ext;
                        addr_reg     <= addr;
                        wdata_reg    <= wdata;
                        ready_reg    <= 1'b0;
                        if (req_err) begin
                            state_reg <= RESP;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end else if (fast_store) begin
                            // Word store overwrites every lane: no need to read first.
                            word_reg  <= wdata;
                            state_reg <= WRITE;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    word_reg <= mem_rd;
                    if (we_reg) begin
                        state_reg <= WRITE;
                    end else begin
                        state_reg <= RESP;
                        done_reg  <= 1'b1;
                        err_reg   <= 1'b0;
                        rdata_reg <= load_value;
                    end
                end
                WRITE: begin
                    state_reg <= RESP;
                    done_reg  <= 1'b1;
                    err_reg   <= 1'b0;
                end
                default: begin
                    // RESP: completion pulse lasts exactly one cycle.
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Memory port: pure decode of state so reset drops it immediately.
    always_comb begin
        mem_we = (state_reg == WRITE);
        mem_a  = 32'd0;
        mem_wd = 32'd0;
        if ((state_reg == READ) || (state_reg == WRITE)) begin
            mem_a = {2'b00, addr_reg[31:2]};
        end
        if (state_reg == WRITE) begin
            mem_wd = merged_word;
        end
    end

    assign ready = ready_reg;
    assign done  = done_reg;
    assign err   = err_reg;
    assign rdata = rdata_reg;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: DEPTH_WORDS, 64, number of 32-bit words in the attached data memory (power of two).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req  input  1  CPU access request; sampled only when ready=1.
REQ-005 SHALL have port: we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: size  input  2  00 = byte, 01 = halfword, 10 = word; 11 = illegal.
REQ-007 SHALL have port: sign_ext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 SHALL have port: addr  input  32  byte address.
REQ-009 SHALL have port: wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port: ready  output  1  high only in IDLE.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: err  output  1  completion status, valid while done=1.
REQ-013 SHALL have port: rdata  output  32  load result, held until the next done.
REQ-014 SHALL have ports to data memory: mem_a  output  32  word index; mem_wd  output  32  write word; mem_we  output  1  write enable; mem_rd  input  32  asynchronous read word.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-016 IDLE: on req=1, latch we/size/sign_ext/addr/wdata; on error go to RESP with err=1, otherwise go to READ.
REQ-017 An error SHALL be: size=11; halfword with addr[0]=1; word with addr[1:0]!=00; addr >= 4*DEPTH_WORDS.
REQ-018 An errored request SHALL never assert mem_we.
REQ-019 READ: mem_a = addr[31:2], mem_we=0, capture mem_rd into the internal word register; next state is RESP for loads and WRITE for stores.
REQ-020 WRITE: mem_we=1 for exactly one cycle, mem_a unchanged; mem_wd = captured word with the addressed lanes replaced by wdata; next state RESP.
REQ-021 Lanes SHALL be little-endian: byte lane k = bits [8k+7:8k], k=addr[1:0]; halfword lane = addr[1]; a word store replaces all 32 bits.
REQ-022 Loads SHALL extract the addressed lane, right-align it, and sign- or zero-extend it per sign_ext; words pass unchanged.
REQ-023 RESP: done=1 for one cycle; rdata updates for successful loads only; next state IDLE.
REQ-024 Latency from the req-accept edge: load done 2 cycles later; store done 3 cycles later; error done 1 cycle later.
REQ-025 req asserted while ready=0 SHALL be ignored and not queued.
REQ-026 Outside READ/WRITE: mem_a=0 and mem_wd=0.
REQ-027 mem_we SHALL be a decode of the WRITE state only.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, ready=1, done=0, err=0, rdata=0, mem_a=0, mem_wd=0, mem_we=0.
REQ-029 Reset during READ or WRITE SHALL abort the access with no memory write and no done pulse.
REQ-030 The first req SHALL be accepted on the first posedge after rst_n deasserts.

Configuration
REQ-031 With FAST_WORD_STORE_EN defined: a legal word store goes IDLE->WRITE directly, mem_wd=wdata, and done comes 2 cycles after accept.
REQ-032 Without FAST_WORD_STORE_EN: word stores take the READ->WRITE path (REQ-019/020) with 3-cycle latency.

Verification (memory preloaded with word k = k)
REQ-033 Load word at addr 0x14 -> done at accept+2, rdata=0x00000005, err=0, mem_we never 1.
REQ-034 Store byte wdata=0x000000AB at addr 0x09 -> a single mem_we cycle with mem_a=2, mem_wd=0x0000AB02; done at accept+3.
REQ-035 Then load byte at 0x09 with sign_ext=1 -> rdata=0xFFFFFFAB; repeat with sign_ext=0 -> rdata=0x000000AB.
REQ-036 Halfword load at 0x03, then word store at 0x100 -> each gives done at accept+1 with err=1; mem_we stays 0; rdata keeps its previous value.
REQ-037 Store halfword 0x1234 at 0x0E, with rst_n pulsed low during WRITE -> word 3 stays 0x00000003, no done pulse, ready=1 after reset.
REQ-038 With FAST_WORD_STORE_EN, store word 0xDEADBEEF at 0x20 -> mem_we cycle at accept+1 with mem_a=8; done at accept+2; a later load returns 0xDEADBEEF.
